// File: rtl/alu_z_stage.sv
// Z-stage ALU: latches operand A into Y from the bus, combines it with bus operand B on start,
// and writes the 64-bit result into ZHI/ZLO. MUL/DIV iterate one bit per cycle.
module alu_z_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] Bus_Mux_out,
  input  logic                  Yin,
  input  logic [3:0]            op,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Y_out,
  output logic [DATA_WIDTH-1:0] ZHI_mux,
  output logic [DATA_WIDTH-1:0] ZLO_mux
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpShr  = 4'd4;
  localparam logic [3:0] OpShra = 4'd5;
  localparam logic [3:0] OpShl  = 4'd6;
  localparam logic [3:0] OpRor  = 4'd7;
  localparam logic [3:0] OpRol  = 4'd8;
  localparam logic [3:0] OpNeg  = 4'd9;
  localparam logic [3:0] OpNot  = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;
  localparam logic [3:0] OpDiv  = 4'd12;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    y_q, zhi_q, zlo_q;
  logic            busy_q, done_q;
  // Shared iteration datapath: hi = partial product / partial remainder, lo = multiplier /
  // dividend shifting out while product bits / quotient bits shift in.
  logic [W:0]      hi_q;
  logic [W-1:0]    lo_q, mag_q, dvd_q;
  logic            neg_q, rem_neg_q, div0_q;

  logic [W-1:0]            a, b, a_mag, b_mag, alu_res;
  logic [SHAMT_BITS-1:0]   sh;
  logic [2*W-1:0]          rot_r, rot_l;
  logic [W:0]              mul_sum, mul_hi_nx, div_sh, div_hi_nx;
  logic [W-1:0]            mul_lo_nx, div_lo_nx, quot_fix, rem_fix;
  logic [2*W-1:0]          prod, prod_fix;
  logic                    div_ge, last;

  always_comb begin
    a     = y_q;
    b     = Bus_Mux_out;
    sh    = b[SHAMT_BITS-1:0];
    a_mag = a[W-1] ? -a : a;
    b_mag = b[W-1] ? -b : b;
    rot_r = {a, a} >> sh;
    rot_l = {a, a} << sh;

    alu_res = '0;
    case (op)
      OpAdd:   alu_res = a + b;
      OpSub:   alu_res = a - b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpShr:   alu_res = a >> sh;
      OpShra:  alu_res = $signed(a) >>> sh;
      OpShl:   alu_res = a << sh;
      OpRor:   alu_res = rot_r[W-1:0];
      OpRol:   alu_res = rot_l[2*W-1:W];
      OpNeg:   alu_res = -b;
      OpNot:   alu_res = ~b;
      default: alu_res = '0;
    endcase

    mul_sum   = {1'b0, hi_q[W-1:0]} + (lo_q[0] ? {1'b0, mag_q} : '0);
    mul_hi_nx = {1'b0, mul_sum[W:1]};
    mul_lo_nx = {mul_sum[0], lo_q[W-1:1]};
    prod      = {mul_hi_nx[W-1:0], mul_lo_nx};
    prod_fix  = neg_q ? -prod : prod;

    div_sh    = {hi_q[W-1:0], lo_q[W-1]};
    div_ge    = div_sh >= {1'b0, mag_q};
    div_hi_nx = div_ge ? div_sh - {1'b0, mag_q} : div_sh;
    div_lo_nx = {lo_q[W-2:0], div_ge};
    quot_fix  = neg_q ? -div_lo_nx : div_lo_nx;
    rem_fix   = rem_neg_q ? -div_hi_nx[W-1:0] : div_hi_nx[W-1:0];

    last = (cnt_q == CntW'(W - 1));
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      mag_q     <= '0;
      dvd_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Yin) y_q <= b;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (op == OpMul) begin
              state_q <= StMul;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              hi_q    <= '0;
              lo_q    <= b_mag;
              mag_q   <= a_mag;
              neg_q   <= a[W-1] ^ b[W-1];
            end else if (op == OpDiv) begin
              state_q   <= StDiv;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              hi_q      <= '0;
              lo_q      <= a_mag;
              mag_q     <= b_mag;
              neg_q     <= a[W-1] ^ b[W-1];
              rem_neg_q <= a[W-1];
              div0_q    <= (b == '0);
              dvd_q     <= a;
            end else begin
              zhi_q  <= '0;
              zlo_q  <= alu_res;
              done_q <= 1'b1;
            end
          end
        end
        StMul: begin
          hi_q  <= mul_hi_nx;
          lo_q  <= mul_lo_nx;
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            {zhi_q, zlo_q} <= prod_fix;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        StDiv: begin
          hi_q  <= div_hi_nx;
          lo_q  <= div_lo_nx;
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            // Divide by zero: all-ones quotient, dividend passed through as remainder.
            if (div0_q) begin
              zhi_q <= dvd_q;
              zlo_q <= '1;
            end else begin
              zhi_q <= rem_fix;
              zlo_q <= quot_fix;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Y_out   = y_q;
  assign ZHI_mux = zhi_q;
  assign ZLO_mux = zlo_q;

endmodule

// File: tb/tb_alu_z_stage.sv
// Directed and randomized checks of alu_z_stage against a plain-arithmetic reference model.
module tb_alu_z_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus;
  logic        yin;
  logic [3:0]  op;
  logic        start;
  logic        busy, done;
  logic [31:0] y_out, zhi, zlo;

  int n_vec = 0;
  int n_mis = 0;

  alu_z_stage #(.DATA_WIDTH(32), .SHAMT_BITS(5)) dut (
    .clk        (clk),
    .clr        (clr),
    .Bus_Mux_out(bus),
    .Yin        (yin),
    .op         (op),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .Y_out      (y_out),
    .ZHI_mux    (zhi),
    .ZLO_mux    (zlo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model straight from the op table, using 64-bit signed arithmetic.
  function automatic logic [63:0] ref_z(input logic [31:0] a, input logic [3:0] o,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] x;
    longint      sa, sb, q, rm, p;
    int          s;
    s  = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'h0;
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a >> s;
      4'd5:  r = 32'(sa >>> s);
      4'd6:  r = a << s;
      4'd7: begin
        x = a;
        for (int i = 0; i < s; i++) x = {x[0], x[31:1]};
        r = x;
      end
      4'd8: begin
        x = a;
        for (int i = 0; i < s; i++) x = {x[30:0], x[31]};
        r = x;
      end
      4'd9:  r = 32'h0 - b;
      4'd10: r = ~b;
      4'd11: begin
        p = sa * sb;
        return p;
      end
      4'd12: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      default: r = 32'h0;
    endcase
    return {32'h0, r};
  endfunction

  task automatic load_y(input logic [31:0] v);
    yin = 1'b1;
    bus = v;
    tick();
    yin = 1'b0;
  endtask

  task automatic run_single(input string tag, input logic [31:0] a, input logic [3:0] o,
                            input logic [31:0] b, input logic [63:0] exp);
    load_y(a);
    start = 1'b1;
    op    = o;
    bus   = b;
    tick();
    start = 1'b0;
    bus   = $urandom;
    check(tag, {zhi, zlo}, exp);
    check_bit({tag, "_done"}, done, 1'b1);
    check_bit({tag, "_busy"}, busy, 1'b0);
    tick();
    check_bit({tag, "_done_end"}, done, 1'b0);
  endtask

  // disturb: extra start plus Yin mid-op. chain: issue AND start in the done cycle.
  task automatic run_iter(input string tag, input logic [31:0] a, input logic [3:0] o,
                          input logic [31:0] b, input logic [63:0] exp, input bit disturb,
                          input bit chain);
    int cyc;
    bit busy_ok;
    cyc     = 0;
    busy_ok = 1'b1;
    load_y(a);
    start = 1'b1;
    op    = o;
    bus   = b;
    tick();
    start = 1'b0;
    while (!done && cyc < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (disturb && cyc == 10) begin
        start = 1'b1;
        op    = 4'd0;
        yin   = 1'b1;
        bus   = 32'h1234_5678;
      end else begin
        start = 1'b0;
        yin   = 1'b0;
        bus   = $urandom;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    yin   = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check_bit({tag, "_busy_held"}, busy_ok, 1'b1);
    check_bit({tag, "_busy_at_done"}, busy, 1'b0);
    check(tag, {zhi, zlo}, exp);
    if (disturb) check({tag, "_yin_mid"}, {32'h0, y_out}, {32'h0, 32'h1234_5678});
    if (chain) begin
      start = 1'b1;
      op    = 4'd2;
      bus   = 32'h0F0F_0F0F;
    end
    tick();
    start = 1'b0;
    if (chain) begin
      check_bit({tag, "_chain_done"}, done, 1'b1);
      check({tag, "_chain_z"}, {zhi, zlo}, {32'h0, a & 32'h0F0F_0F0F});
      tick();
    end
    check_bit({tag, "_done_end"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    int          ndone;

    clr   = 1'b0;
    bus   = 32'h0;
    yin   = 1'b0;
    op    = 4'd0;
    start = 1'b0;
    tick();
    tick();
    check("reset_z", {zhi, zlo}, 64'h0);
    check("reset_y", {32'h0, y_out}, 64'h0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    clr = 1'b1;
    tick();

    run_single("add", 32'd5, 4'd0, 32'd7, 64'd12);
    run_single("ror", 32'h8000_0001, 4'd7, 32'd1, {32'h0, 32'hC000_0000});
    run_single("shra", 32'h8000_0001, 4'd5, 32'd4, {32'h0, 32'hF800_0000});
    run_single("rol", 32'h8000_0001, 4'd8, 32'd1, {32'h0, 32'h0000_0003});
    run_single("shl_sh0", 32'hDEAD_BEEF, 4'd6, 32'h0000_0020, {32'h0, 32'hDEAD_BEEF});
    run_single("sub_wrap", 32'd3, 4'd1, 32'd5, {32'h0, 32'hFFFF_FFFE});
    run_single("neg", 32'd0, 4'd9, 32'd1, {32'h0, 32'hFFFF_FFFF});
    run_single("reserved", 32'hFFFF_FFFF, 4'd14, 32'hFFFF_FFFF, 64'h0);

    run_iter("mul_neg", 32'hFFFF_FFFD, 4'd11, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
    run_iter("div_7_m2", 32'd7, 4'd12, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 1'b0, 1'b0);
    run_iter("div_ovf", 32'h8000_0000, 4'd12, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0,
             1'b0);
    run_iter("div_m7_2", 32'hFFFF_FFF9, 4'd12, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0,
             1'b0);
    run_iter("div0", 32'd9, 4'd12, 32'd0, {32'd9, 32'hFFFF_FFFF}, 1'b0, 1'b0);
    run_iter("div0_dist", 32'd9, 4'd12, 32'd0, {32'd9, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    run_iter("mul_chain", 32'h1234_5678, 4'd11, 32'hFEDC_BA98,
             ref_z(32'h1234_5678, 4'd11, 32'hFEDC_BA98), 1'b0, 1'b1);

    // Abort a MUL with reset part-way through.
    load_y(32'hFFFF_FFFD);
    start = 1'b1;
    op    = 4'd11;
    bus   = 32'd7;
    tick();
    start = 1'b0;
    repeat (15) tick();
    clr = 1'b0;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check("abort_z", {zhi, zlo}, 64'h0);
    tick();
    clr   = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_z_held", {zhi, zlo}, 64'h0);
    run_single("add_after_abort", 32'd100, 4'd0, 32'd23, 64'd123);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 4'($urandom_range(0, 15));
      if (ro == 4'd11 || ro == 4'd12) ro = 4'd2;
      run_single("rand_single", ra, ro, rb, ref_z(ra, ro, rb));
    end
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 5) rb = rb >> 20;
      run_iter("rand_mul", ra, 4'd11, rb, ref_z(ra, 4'd11, rb), 1'b0, 1'b0);
      run_iter("rand_div", ra, 4'd12, rb, ref_z(ra, 4'd12, rb), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
